// File: rtl/uop_cache_pkg.sv
// Shared definitions for the uop-cache controllers: sizes, FSM state encoding,
// control-transfer opcodes used by the loop detector, and a PC helper.
package uop_cache_pkg;

  localparam int DEPTH = 64;
  localparam int AW    = 6;
  localparam int LW    = AW + 1;
  localparam int XLEN  = 32;
  localparam int ITERW = 16;

  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_BTYPE = 7'b1100011;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_FILL   = 2'd1,
    ST_REPLAY = 2'd2
  } seq_state_t;

  // PC of loop entry idx: base + 4*idx, wrapping at XLEN bits
  function automatic logic [XLEN-1:0] entry_pc(input logic [XLEN-1:0] base,
                                               input logic [AW-1:0]   idx);
    return base + {{(XLEN-AW-2){1'b0}}, idx, 2'b00};
  endfunction

  // True for any control-transfer instruction (JAL, JALR, conditional branch)
  function automatic logic is_ctrl_xfer(input logic [XLEN-1:0] instr);
    return (instr[6:0] == OPC_JAL) || (instr[6:0] == OPC_BTYPE) ||
           (instr[6:0] == OPC_JALR);
  endfunction

endpackage

// File: rtl/uop_replay_sequencer_if.sv
// Bundle of the sequencer's front-end, decode and uop-cache BRAM signals.
// master = surrounding pipeline / BRAM side, slave = the sequencer itself.
interface uop_replay_sequencer_if;
  import uop_cache_pkg::*;

  logic            fill_valid;
  logic [XLEN-1:0] fill_instr;
  logic            fill_done;
  logic            fill_abort;
  logic [XLEN-1:0] start_pc;
  logic            mispredict;
  logic            replay_stall;
  logic [XLEN-1:0] bram_rdata;

  logic            bram_we;
  logic [AW-1:0]   bram_waddr;
  logic [XLEN-1:0] bram_wdata;
  logic            bram_re;
  logic [AW-1:0]   bram_raddr;
  logic            out_valid;
  logic [XLEN-1:0] out_instr;
  logic [XLEN-1:0] out_pc;
  logic            fetch_block;
  logic            flush;
  logic [ITERW-1:0] iter_count;

  modport master (
    output fill_valid, fill_instr, fill_done, fill_abort, start_pc,
           mispredict, replay_stall, bram_rdata,
    input  bram_we, bram_waddr, bram_wdata, bram_re, bram_raddr,
           out_valid, out_instr, out_pc, fetch_block, flush, iter_count
  );

  modport slave (
    input  fill_valid, fill_instr, fill_done, fill_abort, start_pc,
           mispredict, replay_stall, bram_rdata,
    output bram_we, bram_waddr, bram_wdata, bram_re, bram_raddr,
           out_valid, out_instr, out_pc, fetch_block, flush, iter_count
  );

endinterface

// File: rtl/uop_replay_addr_gen.sv
// Replay read-address generator: walks 0..len-1 and wraps, counting completed
// iterations (saturating). A stalled cycle simply does not advance.
module uop_replay_addr_gen
  import uop_cache_pkg::*;
(
  input  logic             clk,
  input  logic             reset,
  input  logic             clear_i,
  input  logic             advance_i,
  input  logic             clear_iter_i,
  input  logic [LW-1:0]    len_i,
  output logic [AW-1:0]    raddr_o,
  output logic [ITERW-1:0] iter_count_o
);

  logic [AW-1:0]    raddr_q, raddr_d;
  logic [ITERW-1:0] iter_q, iter_d;
  logic             wrap;

  // Next address and iteration count; the last entry of the body wraps to 0
  always_comb begin
    wrap    = advance_i && (({1'b0, raddr_q} + LW'(1)) == len_i);
    raddr_d = raddr_q;
    iter_d  = iter_q;
    if (clear_i) begin
      raddr_d = '0;
    end else if (advance_i) begin
      raddr_d = wrap ? '0 : raddr_q + AW'(1);
    end
    if (clear_iter_i) begin
      iter_d = '0;
    end else if (wrap && (iter_q != '1)) begin
      iter_d = iter_q + ITERW'(1);
    end
  end

  // Address and iteration registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      raddr_q <= '0;
      iter_q  <= '0;
    end else begin
      raddr_q <= raddr_d;
      iter_q  <= iter_d;
    end
  end

  assign raddr_o      = raddr_q;
  assign iter_count_o = iter_q;

endmodule

// File: rtl/uop_replay_sequencer.sv
// Uop-cache controller: captures one loop body into BRAM, then replays it into
// decode with fetch blocked until a mispredict ends the loop.
module uop_replay_sequencer
  import uop_cache_pkg::*;
(
  input  logic                  clk,
  input  logic                  reset,
  uop_replay_sequencer_if.slave bus
);

  seq_state_t       state_q, state_d;
  logic [AW-1:0]    waddr_q, waddr_d;
  logic [LW-1:0]    len_q, len_d;
  logic [XLEN-1:0]  start_pc_q, start_pc_d;
  logic             out_valid_q, out_valid_d;
  logic [XLEN-1:0]  out_pc_q, out_pc_d;
  logic             flush_q, flush_d;

  logic             kill;
  logic             in_replay;
  logic             at_last;
  logic             fill_start;
  logic             wr_en;
  logic             rd_issue;
  logic             valid_now;
  logic [AW-1:0]    raddr;
  logic [ITERW-1:0] iter_cnt;

  assign kill       = bus.mispredict || bus.fill_abort;
  assign in_replay  = (state_q == ST_REPLAY);
  assign at_last    = (waddr_q == AW'(DEPTH - 1));
  assign fill_start = (state_q == ST_IDLE) && bus.fill_valid && !kill;
  assign wr_en      = fill_start ||
                      ((state_q == ST_FILL) && bus.fill_valid && !kill &&
                       (bus.fill_done || !at_last));
  assign rd_issue   = in_replay && !bus.mispredict && !bus.replay_stall;
  assign valid_now  = out_valid_q && in_replay && !bus.mispredict;

  uop_replay_addr_gen u_addr_gen (
    .clk          (clk),
    .reset        (reset),
    .clear_i      (!in_replay || bus.mispredict),
    .advance_i    (rd_issue),
    .clear_iter_i (fill_start),
    .len_i        (len_q),
    .raddr_o      (raddr),
    .iter_count_o (iter_cnt)
  );

  // FSM state register
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  // Next state: mispredict beats abort beats fill_done; overflow falls back to IDLE
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (fill_start) state_d = bus.fill_done ? ST_REPLAY : ST_FILL;
      end
      ST_FILL: begin
        if (kill) begin
          state_d = ST_IDLE;
        end else if (bus.fill_valid) begin
          if (bus.fill_done)  state_d = ST_REPLAY;
          else if (at_last)   state_d = ST_IDLE;
        end
      end
      ST_REPLAY: begin
        if (bus.mispredict) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Datapath next values: write pointer, loop length, base PC, output pipeline, flush
  always_comb begin
    waddr_d     = waddr_q;
    len_d       = len_q;
    start_pc_d  = start_pc_q;
    out_valid_d = out_valid_q;
    out_pc_d    = out_pc_q;
    flush_d     = in_replay && bus.mispredict;
    if (fill_start) start_pc_d = bus.start_pc;
    if (wr_en && bus.fill_done) len_d = {1'b0, waddr_q} + LW'(1);
    if (state_d == ST_FILL) begin
      if (wr_en) waddr_d = waddr_q + AW'(1);
    end else begin
      waddr_d = '0;
    end
    if (!in_replay || bus.mispredict) begin
      out_valid_d = 1'b0;
      out_pc_d    = '0;
    end else if (rd_issue) begin
      out_valid_d = 1'b1;
      out_pc_d    = entry_pc(start_pc_q, raddr);
    end
  end

  // Datapath registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      waddr_q     <= '0;
      len_q       <= '0;
      start_pc_q  <= '0;
      out_valid_q <= 1'b0;
      out_pc_q    <= '0;
      flush_q     <= 1'b0;
    end else begin
      waddr_q     <= waddr_d;
      len_q       <= len_d;
      start_pc_q  <= start_pc_d;
      out_valid_q <= out_valid_d;
      out_pc_q    <= out_pc_d;
      flush_q     <= flush_d;
    end
  end

  // Outputs: forced to zero while reset is held so they drop before the next edge
  always_comb begin
    bus.bram_we     = 1'b0;
    bus.bram_waddr  = '0;
    bus.bram_wdata  = '0;
    bus.bram_re     = 1'b0;
    bus.bram_raddr  = '0;
    bus.out_valid   = 1'b0;
    bus.out_instr   = '0;
    bus.out_pc      = '0;
    bus.fetch_block = 1'b0;
    bus.flush       = 1'b0;
    bus.iter_count  = '0;
    if (!reset) begin
      bus.bram_we     = wr_en;
      bus.bram_waddr  = wr_en ? waddr_q : '0;
      bus.bram_wdata  = wr_en ? bus.fill_instr : '0;
      bus.bram_re     = rd_issue;
      bus.bram_raddr  = in_replay ? raddr : '0;
      bus.out_valid   = valid_now;
      bus.out_instr   = valid_now ? bus.bram_rdata : '0;
      bus.out_pc      = valid_now ? out_pc_q : '0;
      bus.fetch_block = in_replay && !bus.mispredict;
      bus.flush       = flush_q;
      bus.iter_count  = iter_cnt;
    end
  end

endmodule
